spram_arb2: RTL and testbench
=============================

Name: spram_arb2

Overview:
- Two-port round-robin arbiter and sequencer for the 64x8 single-port RAM (synchronous write, registered read address, combinational read-out).
- Lets two independent requesters (A, B) share the one RAM port. Each has a valid/ready request channel and a registered read-return channel.
- Sits between the requesters and the RAM instance. It drives the RAM's we/address/input_data and samples its output_data.

Parameters:
- ADDR_W, 6, RAM address width (depth 2**ADDR_W).
- DATA_W, 8, RAM data width.
- MAX_BURST, 4, maximum consecutive grants to one locked requester (1..15).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a_req, b_req  in  1  request valid.
- a_we, b_we  in  1  1 = write, 0 = read.
- a_lock, b_lock  in  1  request to keep the grant for the next beat (burst).
- a_addr, b_addr  in  ADDR_W  request address.
- a_wdata, b_wdata  in  DATA_W  write data.
- a_gnt, b_gnt  out  1  request accepted this cycle (combinational).
- a_rvalid, b_rvalid  out  1  read data valid (registered pulse).
- a_rdata, b_rdata  out  DATA_W  read data (registered).
- ram_we  out  1  to RAM we.
- ram_addr  out  ADDR_W  to RAM address.
- ram_wdata  out  DATA_W  to RAM input_data.
- ram_rdata  in  DATA_W  from RAM output_data.

Behaviour:
- **Reset values:** async on rst_n low. Outputs: gnt 0, rvalid 0, rdata 0, ram_we 0, ram_addr 0, ram_wdata 0. Internal: last_gnt = B (so A wins first), burst_cnt 0, owner none, pipeline flags cleared. Reset mid-operation discards pending reads; no rvalid after reset release.
- **Handshake:** req plus its fields must stay stable until gnt. Transfer occurs in the cycle req & gnt = 1. At most one gnt per cycle. Back-to-back grants are allowed every cycle.
- **Arbitration (combinational, from registered state):**
  - Locked owner with req high and burst_cnt < MAX_BURST wins.
  - Otherwise, if only one requester is active, it wins.
  - If both are active, the one not equal to last_gnt wins.
- **State update on grant:**
  - last_gnt <= winner.
  - If winner == previous owner and lock was set on the previous beat, burst_cnt+1; else burst_cnt = 1.
  - owner <= winner if its lock = 1, else none.
  - burst_cnt reaching MAX_BURST forces owner = none. The other requester, if requesting, wins next.
  - Owner dropping req releases ownership immediately.
- **RAM drive (grant cycle N):** ram_we = granted we, ram_addr/ram_wdata = granted fields. With no grant: ram_we = 0, ram_addr/ram_wdata hold their previous values, so the RAM address register keeps pointing to the last address.
- **Write:** RAM updated at the end of cycle N. No response beat.
- **Read:**
  - RAM registers the address at the end of N; ram_rdata is valid during N+1.
  - Arbiter registers it at the end of N+1, so x_rvalid = 1 and x_rdata = data in cycle N+2 (latency 2, one cycle wide).
  - A two-deep tag pipe (valid + requester id) carries the response routing.
  - x_rdata holds its value when x_rvalid = 0.
- **Hazards:**
  - Write then read of the same address in back-to-back cycles returns the new data, since the RAM write completes before the read address is registered.
  - A read followed by a write: the read data is still correct, because the RAM address register is not updated on write cycles.
- **Throughput:** 1 access per cycle total, with pipelined reads overlapping new grants.

Decomposition:
- Shared package: ADDR_W/DATA_W defaults, requester id encoding (REQ_A = 0, REQ_B = 1), and MAX_BURST default.
- One natural sub-module: spram_arb2_rr, the pure 2-way round-robin/lock pick logic with burst counter. The top holds the muxes and the read-return pipe.
- The RAM itself stays external; the bench instantiates it.

Test Plan:
- Reset, then A reads addr 5 (preloaded 0x3C) at cycle 2 → a_gnt at cycle 2, a_rvalid = 1 with a_rdata = 0x3C at cycle 4, b_rvalid stays 0.
- A and B both request continuously, no lock → grants alternate A, B, A, B starting with A; each reads its own address; rvalid routing matches 2 cycles later.
- A writes 0x7E to addr 10 at cycle N, B reads addr 10 at N+1 → b_rdata = 0x7E at N+3.
- A lock = 1 with continuous req, B requesting, MAX_BURST = 4 → A granted 4 consecutive cycles, then B, then A again.
- Read granted at cycle N, rst_n pulsed low at N+1 → a_rvalid never asserts, all outputs 0; first post-reset contention is granted to A.
- Read addr 63, then write addr 0, then read addr 0 → the addr 63 data is correct, and the final read returns the written value (wrap/boundary addresses).

Source files
------------

// File: rtl/spram_arb2_pkg.sv
// Shared constants and types for the two-port RAM arbiter.
package spram_arb2_pkg;

  localparam int unsigned ADDR_W_DEF    = 6;
  localparam int unsigned DATA_W_DEF    = 8;
  localparam int unsigned MAX_BURST_DEF = 4;

  // Burst counter width; large enough for MAX_BURST up to 15.
  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

endpackage

// File: rtl/spram_arb2_rr.sv
// Two-way round-robin pick with burst locking.
module spram_arb2_rr
  import spram_arb2_pkg::*;
#(
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_req,
  input  logic b_req,
  input  logic a_lock,
  input  logic b_lock,
  output logic a_gnt,
  output logic b_gnt
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_BURST);

  req_id_e          last_gnt_q, last_gnt_d;
  req_id_e          owner_q, owner_d;
  logic             owner_vld_q, owner_vld_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic    owner_req;
  req_id_e win_id;
  logic    win_lock;

  // Grant decision from registered state: locked owner, then sole requester, then alternate.
  always_comb begin
    a_gnt     = 1'b0;
    b_gnt     = 1'b0;
    owner_req = (owner_q == REQ_A) ? a_req : b_req;
    if (owner_vld_q && owner_req && (burst_cnt_q < MaxCnt)) begin
      if (owner_q == REQ_A) a_gnt = 1'b1;
      else                  b_gnt = 1'b1;
    end else if (a_req && b_req) begin
      if (last_gnt_q == REQ_A) b_gnt = 1'b1;
      else                     a_gnt = 1'b1;
    end else begin
      a_gnt = a_req;
      b_gnt = b_req;
    end
  end

  // Arbitration state update on each grant.
  always_comb begin
    last_gnt_d  = last_gnt_q;
    owner_d     = owner_q;
    owner_vld_d = owner_vld_q;
    burst_cnt_d = burst_cnt_q;
    win_id      = b_gnt ? REQ_B : REQ_A;
    win_lock    = b_gnt ? b_lock : a_lock;
    if (a_gnt || b_gnt) begin
      last_gnt_d  = win_id;
      burst_cnt_d = (owner_vld_q && (owner_q == win_id)) ? burst_cnt_q + CNT_W'(1) : CNT_W'(1);
      // Hitting the burst limit hands the port back to normal round-robin.
      owner_vld_d = win_lock && (burst_cnt_d < MaxCnt);
      owner_d     = win_id;
    end else if (owner_vld_q && !owner_req) begin
      owner_vld_d = 1'b0;
    end
  end

  // State registers; A wins the first contention after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q  <= REQ_B;
      owner_q     <= REQ_A;
      owner_vld_q <= 1'b0;
      burst_cnt_q <= '0;
    end else begin
      last_gnt_q  <= last_gnt_d;
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: rtl/spram_arb2.sv
// Two-requester sequencer for a single-port RAM with a two-cycle read return.
module spram_arb2
  import spram_arb2_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              b_req,
  input  logic              a_we,
  input  logic              b_we,
  input  logic              a_lock,
  input  logic              b_lock,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_rvalid,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  logic              gnt_any;
  req_id_e           gnt_id;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic              rd_vld_q, rd_vld_d;
  req_id_e           rd_id_q, rd_id_d;
  logic              a_rvalid_q, a_rvalid_d;
  logic              b_rvalid_q, b_rvalid_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

  spram_arb2_rr #(
    .MAX_BURST(MAX_BURST)
  ) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .a_req (a_req),
    .b_req (b_req),
    .a_lock(a_lock),
    .b_lock(b_lock),
    .a_gnt (a_gnt),
    .b_gnt (b_gnt)
  );

  // Route the granted request onto the RAM port; idle cycles keep the last address.
  always_comb begin
    gnt_any   = a_gnt | b_gnt;
    gnt_id    = b_gnt ? REQ_B : REQ_A;
    sel_we    = b_gnt ? b_we    : a_we;
    sel_addr  = b_gnt ? b_addr  : a_addr;
    sel_wdata = b_gnt ? b_wdata : a_wdata;
    ram_we    = gnt_any & sel_we;
    ram_addr  = gnt_any ? sel_addr  : ram_addr_q;
    ram_wdata = gnt_any ? sel_wdata : ram_wdata_q;
  end

  // Read tag pipe: stage 1 tracks the RAM address register, stage 2 is the return register.
  always_comb begin
    rd_vld_d   = gnt_any & ~sel_we;
    rd_id_d    = gnt_id;
    a_rvalid_d = rd_vld_q & (rd_id_q == REQ_A);
    b_rvalid_d = rd_vld_q & (rd_id_q == REQ_B);
    a_rdata_d  = a_rvalid_d ? ram_rdata : a_rdata_q;
    b_rdata_d  = b_rvalid_d ? ram_rdata : b_rdata_q;
  end

  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;

  // Hold registers and read return pipe; reset drops any read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rd_vld_q    <= 1'b0;
      rd_id_q     <= REQ_A;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      ram_addr_q  <= ram_addr;
      ram_wdata_q <= ram_wdata;
      rd_vld_q    <= rd_vld_d;
      rd_id_q     <= rd_id_d;
      a_rvalid_q  <= a_rvalid_d;
      b_rvalid_q  <= b_rvalid_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
    end
  end

endmodule

// File: tb/tb_spram_arb2.sv
// Randomized and directed bench for spram_arb2 with an external 64x8 RAM model.
module tb_spram_arb2;

  localparam int MAX_BURST = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_req, b_req, a_we, b_we, a_lock, b_lock;
  logic [5:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic       ram_we;
  logic [5:0] ram_addr;
  logic [7:0] ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  spram_arb2 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_req    (a_req),
    .b_req    (b_req),
    .a_we     (a_we),
    .b_we     (b_we),
    .a_lock   (a_lock),
    .b_lock   (b_lock),
    .a_addr   (a_addr),
    .b_addr   (b_addr),
    .a_wdata  (a_wdata),
    .b_wdata  (b_wdata),
    .a_gnt    (a_gnt),
    .b_gnt    (b_gnt),
    .a_rvalid (a_rvalid),
    .b_rvalid (b_rvalid),
    .a_rdata  (a_rdata),
    .b_rdata  (b_rdata),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  function automatic logic [7:0] init_val(int i);
    if (i == 5) return 8'h3C;
    return 8'((i * 37 + 11) & 255);
  endfunction

  // Single-port RAM: sync write, address register only loads on non-write cycles.
  logic       init_done = 1'b0;
  logic [7:0] ram_mem [64];
  logic [5:0] ram_areg;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 64; i++) ram_mem[i] <= init_val(i);
      ram_areg <= '0;
    end else if (ram_we) begin
      ram_mem[ram_addr] <= ram_wdata;
    end else begin
      ram_areg <= ram_addr;
    end
  end
  assign ram_rdata = ram_mem[ram_areg];

  // Reference model: memory image, grant history (id 2 = no grant), expected returns.
  typedef struct {
    int         due;
    int         id;
    logic [7:0] data;
  } exp_t;

  logic [7:0] m_mem [64];
  int         h_id[$];
  bit         h_lock[$];
  exp_t       expq[$];
  int         m_last;
  logic [7:0] m_ad, m_bd;
  logic [5:0] m_ram_addr;
  logic [7:0] m_ram_wdata;
  int         cyc;
  int         total = 0;
  int         bad = 0;

  logic       obs_a_gnt, obs_b_gnt, obs_a_rvalid, obs_b_rvalid;
  logic [7:0] obs_a_rdata, obs_b_rdata;

  task automatic model_reset();
    expq.delete();
    h_id.delete();
    h_lock.delete();
    m_last      = 1;
    m_ad        = '0;
    m_bd        = '0;
    m_ram_addr  = '0;
    m_ram_wdata = '0;
  endtask

  // Winner from the grant history: a locked streak continues until MAX_BURST grants.
  function automatic int model_pick();
    int n, x, run, k;
    n = h_id.size();
    if (n > 0 && h_id[n-1] != 2 && h_lock[n-1]) begin
      x   = h_id[n-1];
      run = 1;
      k   = n - 1;
      while (k > 0 && h_id[k-1] == x && h_lock[k-1]) begin
        run++;
        k--;
      end
      run = ((run - 1) % MAX_BURST) + 1;
      if (run < MAX_BURST && ((x == 0 && a_req) || (x == 1 && b_req))) return x;
    end
    if (a_req && b_req) return (m_last == 0) ? 1 : 0;
    if (a_req) return 0;
    if (b_req) return 1;
    return 2;
  endfunction

  // One clock: check the cycle against the model, advance the model, move to next negedge.
  task automatic tick();
    int         pick;
    logic [1:0] eg;
    exp_t       e;
    logic       av, bv, xw, xl, ew;
    logic [5:0] xa, ea;
    logic [7:0] xd, ed;
    #1;
    obs_a_gnt    = a_gnt;
    obs_b_gnt    = b_gnt;
    obs_a_rvalid = a_rvalid;
    obs_b_rvalid = b_rvalid;
    obs_a_rdata  = a_rdata;
    obs_b_rdata  = b_rdata;
    pick = model_pick();
    eg = (pick == 0) ? 2'b10 : (pick == 1) ? 2'b01 : 2'b00;
    total++;
    if ({a_gnt, b_gnt} !== eg) begin
      bad++;
      $display("FAIL gnt cyc=%0d got ab=%b want %b", cyc, {a_gnt, b_gnt}, eg);
    end
    av = 1'b0;
    bv = 1'b0;
    if (expq.size() > 0 && expq[0].due == cyc) begin
      e = expq.pop_front();
      if (e.id == 0) begin av = 1'b1; m_ad = e.data; end
      else           begin bv = 1'b1; m_bd = e.data; end
    end
    total++;
    if ({a_rvalid, a_rdata} !== {av, m_ad}) begin
      bad++;
      $display("FAIL a_ret cyc=%0d got v=%b d=%h want v=%b d=%h", cyc, a_rvalid, a_rdata, av, m_ad);
    end
    total++;
    if ({b_rvalid, b_rdata} !== {bv, m_bd}) begin
      bad++;
      $display("FAIL b_ret cyc=%0d got v=%b d=%h want v=%b d=%h", cyc, b_rvalid, b_rdata, bv, m_bd);
    end
    xw = (pick == 1) ? b_we    : a_we;
    xl = (pick == 1) ? b_lock  : a_lock;
    xa = (pick == 1) ? b_addr  : a_addr;
    xd = (pick == 1) ? b_wdata : a_wdata;
    ew = (pick != 2) && xw;
    ea = (pick != 2) ? xa : m_ram_addr;
    ed = (pick != 2) ? xd : m_ram_wdata;
    total++;
    if ({ram_we, ram_addr, ram_wdata} !== {ew, ea, ed}) begin
      bad++;
      $display("FAIL ram_drive cyc=%0d got we=%b a=%h d=%h want we=%b a=%h d=%h",
               cyc, ram_we, ram_addr, ram_wdata, ew, ea, ed);
    end
    if (pick != 2) begin
      if (xw) m_mem[xa] = xd;
      else    expq.push_back('{due: cyc + 2, id: pick, data: m_mem[xa]});
      m_ram_addr  = xa;
      m_ram_wdata = xd;
      m_last      = pick;
    end
    h_id.push_back(pick);
    h_lock.push_back((pick != 2) && xl);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle_inputs();
    a_req = 0; b_req = 0; a_we = 0; b_we = 0; a_lock = 0; b_lock = 0;
    a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
  endtask

  task automatic check_all_zero(string name);
    total++;
    if ({a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata, ram_we, ram_addr, ram_wdata} !== '0) begin
      bad++;
      $display("FAIL %s got gnt=%b%b rv=%b%b rd=%h/%h we=%b a=%h d=%h want all 0", name,
               a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata, ram_we, ram_addr, ram_wdata);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    #1;
    check_all_zero("reset_outputs");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    for (int i = 0; i < 64; i++) m_mem[i] = init_val(i);
    @(negedge clk);
    init_done = 1'b1;
    do_reset();
  endtask

  task automatic test_single_read();
    tick();
    tick();
    a_req = 1; a_we = 0; a_addr = 6'd5;
    tick();
    total++;
    if (obs_a_gnt !== 1'b1 || cyc != 3) begin
      bad++;
      $display("FAIL single_gnt got %b at cyc %0d want 1 at 2", obs_a_gnt, cyc - 1);
    end
    a_req = 0;
    tick();
    tick();
    total++;
    if ({obs_a_rvalid, obs_a_rdata, obs_b_rvalid} !== {1'b1, 8'h3C, 1'b0}) begin
      bad++;
      $display("FAIL single_ret got v=%b d=%h bv=%b want v=1 d=3c bv=0",
               obs_a_rvalid, obs_a_rdata, obs_b_rvalid);
    end
    tick();
  endtask

  task automatic test_alternate();
    int errs = 0;
    do_reset();
    a_req = 1; b_req = 1; a_we = 0; b_we = 0;
    a_addr = 6'($urandom_range(0, 63));
    b_addr = 6'($urandom_range(0, 63));
    for (int i = 0; i < 8; i++) begin
      tick();
      if ({obs_a_gnt, obs_b_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) errs++;
      if (obs_a_gnt) a_addr = 6'($urandom_range(0, 63));
      if (obs_b_gnt) b_addr = 6'($urandom_range(0, 63));
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL alternate got %0d out-of-order grants want 0", errs);
    end
    idle_inputs();
    tick();
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    a_req = 1; a_we = 1; a_addr = 6'd10; a_wdata = 8'h7E;
    tick();
    a_req = 0; a_we = 0;
    b_req = 1; b_we = 0; b_addr = 6'd10;
    tick();
    b_req = 0;
    tick();
    tick();
    total++;
    if ({obs_b_rvalid, obs_b_rdata} !== {1'b1, 8'h7E}) begin
      bad++;
      $display("FAIL wr_rd_hazard got v=%b d=%h want v=1 d=7e", obs_b_rvalid, obs_b_rdata);
    end
    tick();
  endtask

  task automatic test_lock_burst();
    logic [11:0] seq;
    do_reset();
    a_req = 1; a_lock = 1; a_we = 0; a_addr = 6'd20;
    b_req = 1; b_we = 0; b_addr = 6'd21;
    seq = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seq = {seq[9:0], obs_a_gnt, obs_b_gnt};
    end
    total++;
    if (seq !== 12'b10_10_10_10_01_10) begin
      bad++;
      $display("FAIL lock_burst got %b want 101010100110", seq);
    end
    idle_inputs();
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    a_req = 1; a_we = 0; a_addr = 6'd7;
    tick();
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check_all_zero("mid_reset_outputs");
    @(negedge clk);
    @(negedge clk);
    #1;
    check_all_zero("mid_reset_hold");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (obs_a_rvalid !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL mid_reset_rvalid got %0d pulses want 0", seen);
    end
    a_req = 1; b_req = 1; a_addr = 6'd1; b_addr = 6'd2;
    tick();
    total++;
    if ({obs_a_gnt, obs_b_gnt} !== 2'b10) begin
      bad++;
      $display("FAIL post_reset_first got ab=%b want 10", {obs_a_gnt, obs_b_gnt});
    end
    a_req = 0;
    tick();
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_boundary();
    a_req = 1; a_we = 0; a_addr = 6'd63;
    tick();
    a_req = 0;
    b_req = 1; b_we = 1; b_addr = 6'd0; b_wdata = 8'hA5;
    tick();
    b_req = 0; b_we = 0;
    a_req = 1; a_we = 0; a_addr = 6'd0;
    tick();
    a_req = 0;
    total++;
    if ({obs_a_rvalid, obs_a_rdata} !== {1'b1, init_val(63)}) begin
      bad++;
      $display("FAIL addr63_read got v=%b d=%h want v=1 d=%h", obs_a_rvalid, obs_a_rdata,
               init_val(63));
    end
    tick();
    tick();
    total++;
    if ({obs_a_rvalid, obs_a_rdata} !== {1'b1, 8'hA5}) begin
      bad++;
      $display("FAIL addr0_readback got v=%b d=%h want v=1 d=a5", obs_a_rvalid, obs_a_rdata);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (!a_req && $urandom_range(0, 2) != 0) begin
        a_req   = 1;
        a_we    = 1'($urandom_range(0, 1));
        a_lock  = ($urandom_range(0, 2) == 0);
        a_addr  = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 3)) : 6'($urandom_range(0, 63));
        a_wdata = 8'($urandom);
      end
      if (!b_req && $urandom_range(0, 2) != 0) begin
        b_req   = 1;
        b_we    = 1'($urandom_range(0, 1));
        b_lock  = ($urandom_range(0, 2) == 0);
        b_addr  = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 3)) : 6'($urandom_range(0, 63));
        b_wdata = 8'($urandom);
      end
      tick();
      if (obs_a_gnt) a_req = 0;
      if (obs_b_gnt) b_req = 0;
    end
    idle_inputs();
    tick();
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_alternate();
    test_back_to_back();
    test_lock_burst();
    test_reset_mid();
    test_boundary();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
